// File: rtl/pipe_seq_ctrl.sv
// pipe_seq_ctrl: per-stage enable/flush sequencer for the N-stage MIPS pipeline.
// Tracks a valid bit and a halt token per stage. Provides run, single-step,
// drain-on-halt and stall/flush arbitration.
// Optional feature macro: PIPE_PERF_CNT_EN adds the cycle and retired counters.
// When it is undefined, both counter outputs are tied to zero.
module pipe_seq_ctrl #(
    parameter int unsigned N_STAGES    = 5,
    parameter int unsigned STALL_STAGE = 1,
    parameter int unsigned FLUSH_DEPTH = 1,
    parameter int unsigned HALT_STAGE  = 1,
    parameter int unsigned NB_CNT      = 32
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_run,
    input  logic                i_debug,
    input  logic                i_step,
    input  logic                i_stall_req,
    input  logic                i_flush_req,
    input  logic                i_halt_seen,
    output logic [N_STAGES-1:0] o_stage_en,
    output logic [N_STAGES-1:0] o_stage_flush,
    output logic [N_STAGES-1:0] o_valid,
    output logic                o_halted,
    output logic                o_busy,
    output logic [NB_CNT-1:0]   o_cycle_cnt,
    output logic [NB_CNT-1:0]   o_retired_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [N_STAGES-1:0] valid_q;
    logic [N_STAGES-1:0] halt_q;
    logic [N_STAGES-1:0] valid_nx;
    logic [N_STAGES-1:0] halt_nx;
    logic                advance;
    logic                stall;
    logic                flush;
    logic                halt_acc;
    logic                fill;

    // Classify the current cycle. Gating with reset keeps the strobes quiet during reset.
    always_comb begin
        advance  = i_reset && (state == ST_RUN || state == ST_STEP || state == ST_DRAIN);
        stall    = advance && i_stall_req;
        flush    = advance && i_flush_req && !i_stall_req;
        halt_acc = advance && i_halt_seen && !i_stall_req
                   && (state == ST_RUN || state == ST_STEP);
        // Nothing younger than an accepted halt is allowed in; DRAIN fetches bubbles.
        fill     = (state != ST_DRAIN) && !halt_acc;
    end

    // Per-stage strobes and next valid / halt-token vectors.
    always_comb begin
        o_stage_en    = '0;
        o_stage_flush = '0;
        valid_nx      = valid_q;
        halt_nx       = halt_q;
        if (advance) begin
            o_stage_en = '1;
            valid_nx   = {valid_q[N_STAGES-2:0], fill};
            halt_nx    = {halt_q[N_STAGES-2:0], 1'b0};
            if (stall) begin
                // Freeze the young side and push a bubble just past it.
                for (int unsigned k = 0; k <= STALL_STAGE; k++) begin
                    o_stage_en[k] = 1'b0;
                    valid_nx[k]   = valid_q[k];
                    halt_nx[k]    = halt_q[k];
                end
                o_stage_flush[STALL_STAGE+1] = 1'b1;
                valid_nx[STALL_STAGE+1]      = 1'b0;
                halt_nx[STALL_STAGE+1]       = 1'b0;
            end else begin
                if (flush) begin
                    for (int unsigned k = 1; k <= FLUSH_DEPTH; k++) begin
                        o_stage_flush[k] = 1'b1;
                        valid_nx[k]      = 1'b0;
                    end
                end
                if (halt_acc) begin
                    // Squash everything younger than the halt and launch its token.
                    for (int unsigned k = 1; k <= HALT_STAGE; k++) begin
                        o_stage_flush[k] = 1'b1;
                        valid_nx[k]      = 1'b0;
                    end
                    halt_nx[HALT_STAGE+1] = 1'b1;
                end
            end
        end
    end

    // Next-state selection.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (i_run && !i_debug) begin
                    state_nx = ST_RUN;
                end else if (i_debug && i_step) begin
                    state_nx = ST_STEP;
                end
            end
            ST_RUN: begin
                if (halt_acc) begin
                    state_nx = ST_DRAIN;
                end else if (i_debug) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_STEP:   state_nx = halt_acc ? ST_DRAIN : ST_IDLE;
            ST_DRAIN:  if (halt_q[N_STAGES-1]) state_nx = ST_HALTED;
            ST_HALTED: state_nx = ST_HALTED;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // State, valid/halt vectors and status flags.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state    <= ST_IDLE;
            valid_q  <= '0;
            halt_q   <= '0;
            o_halted <= 1'b0;
            o_busy   <= 1'b0;
        end else begin
            state    <= state_nx;
            valid_q  <= valid_nx;
            halt_q   <= halt_nx;
            o_halted <= (state_nx == ST_HALTED);
            o_busy   <= (state_nx == ST_RUN) || (state_nx == ST_STEP) || (state_nx == ST_DRAIN);
        end
    end

    assign o_valid = valid_q;

`ifdef PIPE_PERF_CNT_EN
    logic [NB_CNT-1:0] cycle_cnt_q;
    logic [NB_CNT-1:0] retired_cnt_q;

    // Saturating performance counters.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            cycle_cnt_q   <= '0;
            retired_cnt_q <= '0;
        end else begin
            if (advance && (cycle_cnt_q != {NB_CNT{1'b1}})) begin
                cycle_cnt_q <= cycle_cnt_q + NB_CNT'(1);
            end
            if (advance && valid_q[N_STAGES-1] && (retired_cnt_q != {NB_CNT{1'b1}})) begin
                retired_cnt_q <= retired_cnt_q + NB_CNT'(1);
            end
        end
    end

    assign o_cycle_cnt   = cycle_cnt_q;
    assign o_retired_cnt = retired_cnt_q;
`else
    assign o_cycle_cnt   = '0;
    assign o_retired_cnt = '0;
`endif

endmodule
